// File: rtl/issue_queue.sv
// Out-of-order issue queue: collapsing age-ordered buffer between rename and EXE.
// Issues the oldest entry whose two source operands are ready, one per cycle.
module issue_queue #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             entry_allocate_issue,
  input  logic [169:0]     entry_issue,
  input  logic [63:0]      busy,
  input  logic             exe_busyclear_flag,
  input  logic [5:0]       exe_busyclear_reg,
  input  logic             exe_stall,
  output logic             issue_valid,
  output logic [169:0]     issue_entry,
  output logic             issue_halt,
  output logic [CNT_W-1:0] count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] vld_q, rdya_q, rdyb_q;
  logic [169:0]     ent_q [DEPTH];

  logic [DEPTH:0]   vld_ext, rdya_ext, rdyb_ext;
  logic [169:0]     ent_ext [DEPTH+1];

  logic [DEPTH-1:0] vld_n, rdya_n, rdyb_n;
  logic [169:0]     ent_n [DEPTH];

  logic [DEPTH-1:0] elig;
  logic [IDX_W-1:0] win;
  logic             win_found, do_issue, alloc_ok;
  logic             new_rdya, new_rdyb;
  logic [CNT_W-1:0] alloc_idx;

  // Wakeup is bypassed into selection so a same-edge broadcast can issue its consumer.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = vld_q[i]
        & (rdya_q[i] | (exe_busyclear_flag & (ent_q[i][5:0] == exe_busyclear_reg)))
        & (rdyb_q[i] | (exe_busyclear_flag & (ent_q[i][11:6] == exe_busyclear_reg)));
    end
  end

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win       = IDX_W'(i);
        win_found = 1'b1;
      end
    end
  end

  assign do_issue  = win_found & ~exe_stall & ~FLUSH;
  assign alloc_idx = count - CNT_W'(do_issue);
  assign alloc_ok  = entry_allocate_issue & ~FLUSH & ((count != CNT_W'(DEPTH)) | do_issue);

  assign new_rdya = ~busy[entry_issue[5:0]]
    | (exe_busyclear_flag & (exe_busyclear_reg == entry_issue[5:0]));
  assign new_rdyb = ~busy[entry_issue[11:6]]
    | (exe_busyclear_flag & (exe_busyclear_reg == entry_issue[11:6]));

  // An extra empty slot on top lets the collapse read index i+1 uniformly.
  assign vld_ext  = {1'b0, vld_q};
  assign rdya_ext = {1'b0, rdya_q};
  assign rdyb_ext = {1'b0, rdyb_q};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_ext[i] = ent_q[i];
    ent_ext[DEPTH] = '0;
  end

  always_comb begin
    vld_n  = '0;
    rdya_n = '0;
    rdyb_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src = (do_issue && (i >= int'(win))) ? i + 1 : i;
      vld_n[i]  = vld_ext[src];
      rdya_n[i] = rdya_ext[src];
      rdyb_n[i] = rdyb_ext[src];
      ent_n[i]  = ent_ext[src];
      if (exe_busyclear_flag && (ent_n[i][5:0] == exe_busyclear_reg))  rdya_n[i] = 1'b1;
      if (exe_busyclear_flag && (ent_n[i][11:6] == exe_busyclear_reg)) rdyb_n[i] = 1'b1;
      if (alloc_ok && (CNT_W'(i) == alloc_idx)) begin
        vld_n[i]  = 1'b1;
        rdya_n[i] = new_rdya;
        rdyb_n[i] = new_rdyb;
        ent_n[i]  = entry_issue;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_q       <= '0;
      rdya_q      <= '0;
      rdyb_q      <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
      issue_entry <= '0;
    end else if (FLUSH) begin
      vld_q       <= '0;
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      vld_q       <= vld_n;
      rdya_q      <= rdya_n;
      rdyb_q      <= rdyb_n;
      count       <= count + CNT_W'(alloc_ok) - CNT_W'(do_issue);
      issue_valid <= do_issue;
      if (do_issue) issue_entry <= ent_q[win];
    end
  end

  // Payload is qualified by the valid bits, so it needs no reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_n[i];
  end

  assign issue_halt = (count >= CNT_W'(DEPTH - 1));

endmodule
